// File: rtl/sr194_sequencer.sv
// Command sequencer for a 194-type 4-bit universal shift register (LOAD/SHR/SHL/ROR/ROL/SER).
// Optional abort input is enabled by defining SR194_SEQ_ABORT_EN.
module sr194_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             cp,
  input  logic             mr_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic [3:0]       q,
`ifdef SR194_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             s0,
  output logic             s1,
  output logic             dsr,
  output logic             dsl,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_SER  = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  state_t           r_state;
  state_t           w_nextState;
  op_t              r_op;
  op_t              w_nextOp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fill;
  logic [1:0]       r_mode;
  logic [1:0]       w_nextMode;
  logic             w_accept;
  logic             w_abort;
  logic             w_aborted;

  function automatic logic isLeft(input op_t op);
    return (op == OP_SHL) || (op == OP_ROL);
  endfunction

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_nextOp = w_accept ? op_t'(cmd_op) : r_op;

`ifdef SR194_SEQ_ABORT_EN
  logic r_aborted;

  assign w_abort   = abort && ((r_state == ST_LOAD) || (r_state == ST_SHIFT));
  assign w_aborted = r_aborted;

  // Remembers that the running command was cut short so DONE can flag it.
  always_ff @(posedge cp or negedge mr_) begin
    if (!mr_) begin
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end
  end
`else
  assign w_abort   = 1'b0;
  assign w_aborted = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (op_t'(cmd_op))
            OP_LOAD, OP_SER:               w_nextState = ST_LOAD;
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: w_nextState = (cmd_cnt != '0) ? ST_SHIFT : ST_DONE;
            default:                       w_nextState = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        if (w_abort) begin
          w_nextState = ST_DONE;
        end else if ((r_op == OP_SER) && (r_cnt != '0)) begin
          w_nextState = ST_SHIFT;
        end else begin
          w_nextState = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (w_abort || (r_cnt == CNT_W'(1))) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Mode is computed for the upcoming state so s1/s0 come straight from a flop.
  always_comb begin
    w_nextMode = 2'b00;
    case (w_nextState)
      ST_LOAD:  w_nextMode = 2'b11;
      ST_SHIFT: w_nextMode = isLeft(w_nextOp) ? 2'b10 : 2'b01;
      default:  w_nextMode = 2'b00;
    endcase
  end

  always_ff @(posedge cp or negedge mr_) begin
    if (!mr_) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'b00;
      r_op    <= OP_NOP;
      r_cnt   <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_mode  <= w_nextMode;
      if (w_accept) begin
        r_op   <= w_nextOp;
        r_cnt  <= cmd_cnt;
        r_fill <= cmd_fill;
      end else if (r_state == ST_SHIFT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign s1 = r_mode[1];
  assign s0 = r_mode[0];

  // Serial inputs follow q live so rotates feed back the bit leaving this cycle.
  always_comb begin
    cmd_ready  = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_DONE);
    err        = (r_state == ST_DONE) && ((r_op == OP_RSVD) || w_aborted);
    sout_valid = 1'b0;
    sout       = 1'b0;
    dsr        = 1'b0;
    dsl        = 1'b0;
    if (r_state == ST_SHIFT) begin
      sout_valid = 1'b1;
      if (isLeft(r_op)) begin
        sout = q[0];
        dsl  = (r_op == OP_ROL) ? q[0] : r_fill;
      end else begin
        sout = q[3];
        dsr  = (r_op == OP_ROR) ? q[3] : r_fill;
      end
    end
  end

endmodule

// File: tb/tb_sr194_sequencer.sv
// Directed bench for sr194_sequencer with a behavioural 194 register closing the q loop.
// Covers the abort path when SR194_SEQ_ABORT_EN is defined.
module tb_sr194_sequencer;

  localparam int CNT_W = 4;

  logic             cp = 1'b0;
  logic             mr_ = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd_op = 3'b000;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             cmd_fill = 1'b0;
  logic [3:0]       q;
  logic [3:0]       pIn = 4'b0000;
  logic             cmd_ready, s0, s1, dsr, dsl, busy, sout, sout_valid, done, err;
`ifdef SR194_SEQ_ABORT_EN
  logic             abort = 1'b0;
`endif

  int nChecks = 0;
  int nFails  = 0;

  logic [3:0] rolQ   [4] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};
  logic       rolDsl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       serOut [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  sr194_sequencer #(.CNT_W(CNT_W)) dut (
    .cp(cp),
    .mr_(mr_),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_cnt(cmd_cnt),
    .cmd_fill(cmd_fill),
    .q(q),
`ifdef SR194_SEQ_ABORT_EN
    .abort(abort),
`endif
    .s0(s0),
    .s1(s1),
    .dsr(dsr),
    .dsl(dsl),
    .busy(busy),
    .sout(sout),
    .sout_valid(sout_valid),
    .done(done),
    .err(err)
  );

  always #5 cp = ~cp;

  // Behavioural 194: 01 moves Q0 toward Q3 with dsr into Q0, 10 moves Q3 toward Q0 with dsl into Q3.
  always_ff @(posedge cp or negedge mr_) begin
    if (!mr_) begin
      q <= 4'b0000;
    end else begin
      case ({s1, s0})
        2'b01:   q <= {q[2:0], dsr};
        2'b10:   q <= {dsl, q[3:1]};
        2'b11:   q <= pIn;
        default: q <= q;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one command in an IDLE cycle and returns mid-way through the first cycle after accept.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] cnt, input logic fill, input logic [3:0] par);
    @(negedge cp);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    pIn       = par;
    checkOutput("ready_before_accept", cmd_ready, 1);
    @(negedge cp);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_mode", {s1, s0}, 2'b00);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_soutv", sout_valid, 0);
    checkOutput("rst_dsr_dsl", {dsr, dsl}, 2'b00);
    @(negedge cp);
    mr_ = 1'b1;

    applyStimulus(3'b001, 4'd0, 1'b0, 4'b1010);
    checkOutput("load_mode", {s1, s0}, 2'b11);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_ready", cmd_ready, 0);
    @(negedge cp);
    checkOutput("load_q", q, 4'b1010);
    checkOutput("load_done", done, 1);
    checkOutput("load_err", err, 0);
    checkOutput("load_done_mode", {s1, s0}, 2'b00);
    @(negedge cp);
    checkOutput("load_idle_ready", cmd_ready, 1);
    checkOutput("load_idle_done", done, 0);

    applyStimulus(3'b010, 4'd2, 1'b1, 4'b0000);
    checkOutput("shr_c1_mode", {s1, s0}, 2'b01);
    checkOutput("shr_c1_soutv", sout_valid, 1);
    checkOutput("shr_c1_sout", sout, 1);
    checkOutput("shr_c1_dsr_dsl", {dsr, dsl}, 2'b10);
    @(negedge cp);
    checkOutput("shr_c2_q", q, 4'b0101);
    checkOutput("shr_c2_mode", {s1, s0}, 2'b01);
    checkOutput("shr_c2_sout", sout, 0);
    checkOutput("shr_c2_soutv", sout_valid, 1);
    @(negedge cp);
    checkOutput("shr_done", done, 1);
    checkOutput("shr_q", q, 4'b1011);
    checkOutput("shr_done_soutv", sout_valid, 0);

    applyStimulus(3'b001, 4'd0, 1'b0, 4'b1001);
    @(negedge cp);
    @(negedge cp);
    applyStimulus(3'b101, 4'd4, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rol_c%0d_mode", i + 1), {s1, s0}, 2'b10);
      checkOutput($sformatf("rol_c%0d_q", i + 1), q, rolQ[i]);
      checkOutput($sformatf("rol_c%0d_dsl", i + 1), dsl, rolDsl[i]);
      checkOutput($sformatf("rol_c%0d_sout", i + 1), sout, rolDsl[i]);
      @(negedge cp);
    end
    checkOutput("rol_done", done, 1);
    checkOutput("rol_q", q, 4'b1001);

    applyStimulus(3'b110, 4'd4, 1'b0, 4'b0110);
    checkOutput("ser_load_mode", {s1, s0}, 2'b11);
    checkOutput("ser_load_soutv", sout_valid, 0);
    @(negedge cp);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ser_c%0d_mode", i + 2), {s1, s0}, 2'b01);
      checkOutput($sformatf("ser_c%0d_sout", i + 2), sout, serOut[i]);
      @(negedge cp);
    end
    checkOutput("ser_done", done, 1);
    checkOutput("ser_err", err, 0);
    checkOutput("ser_q", q, 4'b0000);

    applyStimulus(3'b011, 4'd0, 1'b1, 4'b0000);
    checkOutput("shl0_done", done, 1);
    checkOutput("shl0_err", err, 0);
    checkOutput("shl0_mode", {s1, s0}, 2'b00);
    @(negedge cp);

    @(negedge cp);
    cmd_valid = 1'b1;
    cmd_op    = 3'b111;
    cmd_cnt   = 4'd3;
    @(negedge cp);
    checkOutput("rsvd_done", done, 1);
    checkOutput("rsvd_err", err, 1);
    checkOutput("rsvd_mode", {s1, s0}, 2'b00);
    checkOutput("rsvd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    @(negedge cp);
    checkOutput("rsvd_idle_busy", busy, 0);
    checkOutput("rsvd_idle_ready", cmd_ready, 1);
    @(negedge cp);
    checkOutput("rsvd_no_second_busy", busy, 0);
    checkOutput("rsvd_no_second_done", done, 0);

    applyStimulus(3'b001, 4'd0, 1'b0, 4'b1111);
    @(negedge cp);
    @(negedge cp);
    applyStimulus(3'b010, 4'd5, 1'b0, 4'b0000);
    checkOutput("mr_c1_mode", {s1, s0}, 2'b01);
    @(negedge cp);
    checkOutput("mr_c2_busy", busy, 1);
    mr_ = 1'b0;
    #1;
    checkOutput("mr_ready", cmd_ready, 1);
    checkOutput("mr_mode", {s1, s0}, 2'b00);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_soutv", sout_valid, 0);
    checkOutput("mr_dsr_dsl", {dsr, dsl}, 2'b00);
    checkOutput("mr_q", q, 4'b0000);
    @(negedge cp);
    mr_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge cp);
      checkOutput($sformatf("mr_after_%0d_done", i), done, 0);
    end
    checkOutput("mr_after_ready", cmd_ready, 1);

`ifdef SR194_SEQ_ABORT_EN
    applyStimulus(3'b001, 4'd0, 1'b0, 4'b1010);
    @(negedge cp);
    @(negedge cp);
    applyStimulus(3'b010, 4'd5, 1'b1, 4'b0000);
    checkOutput("abort_c1_mode", {s1, s0}, 2'b01);
    @(negedge cp);
    checkOutput("abort_c2_q", q, 4'b0101);
    abort = 1'b1;
    @(negedge cp);
    abort = 1'b0;
    checkOutput("abort_done", done, 1);
    checkOutput("abort_err", err, 1);
    checkOutput("abort_mode", {s1, s0}, 2'b00);
    checkOutput("abort_q", q, 4'b1011);
    @(negedge cp);
    checkOutput("abort_idle_ready", cmd_ready, 1);
    checkOutput("abort_idle_q", q, 4'b1011);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
